// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and its consumers.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int FRAME_DATA_BITS = 8;
  // First byte of a key-release sequence (F0 xx).
  localparam logic [7:0] BREAK_CODE = 8'hF0;

endpackage

// File: rtl/ps2_if.sv
// Keyboard line inputs plus the received-byte buffer and status pulses.
interface ps2_if;
  import ps2_pkg::*;

  logic        kb_clk;
  logic        kb_data;
  logic [15:0] buffer_out;
  logic        error;
  logic        valid;

  // master: keyboard/stimulus side; slave: the receiver
  modport master (output kb_clk, kb_data, input buffer_out, error, valid);
  modport slave  (input kb_clk, kb_data, output buffer_out, error, valid);

endinterface

// File: rtl/ps2_sync.sv
// Multi-flop synchroniser for an asynchronous level; resets to the idle-high level.
module ps2_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;
  logic [STAGES-1:0] stage_next;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_next[gi] = d;
      end else begin : g_rest
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) stage_reg <= '1;
    else        stage_reg <= stage_next;
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/ps2.sv
// PS/2 keyboard receiver: oversamples kb_clk/kb_data, deserialises 11-bit frames
// and keeps the last two accepted bytes in a 16-bit shift buffer.
module ps2
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  ps2_if.slave bus
);

  localparam int CW = $clog2(FRAME_DATA_BITS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic kb_clk_s, kb_data_s;
  logic kb_clk_prev_reg;
  logic fall;

  ps2_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .d(bus.kb_clk), .q(kb_clk_s)
  );
  ps2_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d(bus.kb_data), .q(kb_data_s)
  );

  assign fall = kb_clk_prev_reg & ~kb_clk_s;

  ps2_state_t                 state_reg, state_next;
  logic [CW-1:0]              cnt_reg, cnt_next;
  logic [FRAME_DATA_BITS-1:0] shift_reg, shift_next;
  logic                       parity_reg, parity_next;
  logic [TW-1:0]              timeout_reg, timeout_next;
  logic                       commit_reg, commit_next;
  logic                       reject_reg, reject_next;
  logic [15:0]                buffer_reg;
  logic                       valid_reg, error_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    timeout_next = '0;
    commit_next  = 1'b0;
    reject_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fall && !kb_data_s) begin
          state_next = DATA;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_next[cnt_reg] = kb_data_s;
          cnt_next            = cnt_reg + 1'b1;
          if (cnt_reg == CW'(FRAME_DATA_BITS - 1)) state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_next = kb_data_s;
          state_next  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          // Odd parity: data ones plus parity bit must be odd.
          if (kb_data_s && ((^shift_reg) ^ parity_reg)) commit_next = 1'b1;
          else                                          reject_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Mid-frame watchdog; any falling edge restarts the count.
    if (state_reg != IDLE && !fall) begin
      if (timeout_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        reject_next = 1'b1;
        state_next  = IDLE;
      end else begin
        timeout_next = timeout_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kb_clk_prev_reg <= 1'b1;
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      shift_reg       <= '0;
      parity_reg      <= 1'b0;
      timeout_reg     <= '0;
      commit_reg      <= 1'b0;
      reject_reg      <= 1'b0;
      buffer_reg      <= 16'h0000;
      valid_reg       <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      kb_clk_prev_reg <= kb_clk_s;
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      shift_reg       <= shift_next;
      parity_reg      <= parity_next;
      timeout_reg     <= timeout_next;
      commit_reg      <= commit_next;
      reject_reg      <= reject_next;
      valid_reg       <= commit_reg;
      error_reg       <= reject_reg;
      if (commit_reg) buffer_reg <= {buffer_reg[7:0], shift_reg};
    end
  end

  assign bus.buffer_out = buffer_reg;
  assign bus.valid      = valid_reg;
  assign bus.error      = error_reg;

endmodule

// File: tb/tb_ps2.sv
// Randomised and directed frame bench for the PS/2 receiver against a byte-level model.
module tb_ps2;

  localparam int TO   = 400;
  localparam int HALF = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ps2_if bus ();

  ps2 #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_cnt    = 0;
  int error_cnt    = 0;

  logic [15:0] exp_buf   = 16'h0000;
  int          exp_valid = 0;
  int          exp_error = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid) valid_cnt++;
      if (bus.error) error_cnt++;
      if (bus.valid || bus.error) check("valid_error_exclusive", 32'(bus.valid & bus.error), 0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Data changes while kb_clk is high, then kb_clk falls mid-bit.
  task automatic drive_bit(input logic b);
    bus.kb_data = b;
    wait_clk(HALF);
    bus.kb_clk = 1'b0;
  endtask

  task automatic release_clk();
    wait_clk(HALF);
    bus.kb_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drive_bit(bits[i]);
      release_clk();
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {~bad_stop, par ^ bad_par, d, 1'b0};
  endfunction

  task automatic check_totals(input string tag);
    check({tag, "_valid_cnt"}, 32'(valid_cnt), 32'(exp_valid));
    check({tag, "_error_cnt"}, 32'(error_cnt), 32'(exp_error));
    check({tag, "_buffer"}, 32'(bus.buffer_out), 32'(exp_buf));
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    int lat;
    bits = make_frame(d, bad_par, bad_stop);
    send_bits(bits, 10);
    drive_bit(bits[10]);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      wait_clk(1);
      if (lat == 0 && (bus.valid || bus.error)) lat = i;
    end
    check("latency", 32'(lat), 4);
    wait_clk(HALF - 8);
    bus.kb_clk = 1'b1;
    wait_clk(HALF);
    if (!bad_par && !bad_stop) begin
      exp_buf = {exp_buf[7:0], d};
      exp_valid++;
    end else begin
      exp_error++;
    end
    check_totals("frame");
    $display("[TB] frame %02h bad_par=%0d bad_stop=%0d buffer_out=%04h valid=%0d error=%0d",
             d, bad_par, bad_stop, bus.buffer_out, valid_cnt, error_cnt);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    bus.kb_clk  = 1'b1;
    bus.kb_data = 1'b1;
    rst_n       = 1'b0;
    wait_clk(3);
    check("reset_buffer", 32'(bus.buffer_out), 0);
    check("reset_valid", 32'(bus.valid), 0);
    check("reset_error", 32'(bus.error), 0);
    $display("[TB] reset buffer_out=%04h", bus.buffer_out);
    rst_n = 1'b1;
    wait_clk(5);

    // Make and break sequences.
    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);

    // Parity and stop-bit rejects.
    send_frame(8'h29, 1, 0);
    send_frame(8'h29, 0, 1);
    send_frame(8'h29, 0, 0);

    // Stalled frame: start + 4 data bits, then the keyboard clock stops.
    bits = make_frame(8'h5A, 0, 0);
    send_bits(bits, 5);
    wait_clk(TO + 100);
    exp_error++;
    check_totals("timeout");
    $display("[TB] timeout after 5 bits valid=%0d error=%0d", valid_cnt, error_cnt);
    send_frame(8'h5A, 0, 0);

    // Reset in the middle of a frame.
    bits = make_frame(8'h1C, 0, 0);
    send_bits(bits, 7);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    exp_buf = 16'h0000;
    wait_clk(4);
    check_totals("midreset");
    $display("[TB] mid-frame reset buffer_out=%04h error=%0d", bus.buffer_out, error_cnt);
    for (int i = 7; i < 11; i++) begin
      drive_bit(bits[i]);
      release_clk();
    end
    wait_clk(HALF);
    check("tail_no_valid", 32'(valid_cnt), 32'(exp_valid));
    // Any 0 in the leftover tail looks like a start bit and ends in a timeout.
    wait_clk(TO + 100);
    if (bits[10:7] != 4'b1111) exp_error++;
    check_totals("tail");
    $display("[TB] tail bits %04b valid=%0d error=%0d", bits[10:7], valid_cnt, error_cnt);
    send_frame(8'h1C, 0, 0);

    // Random bytes with occasional parity or stop faults.
    for (int n = 0; n < 14; n++) begin
      logic [7:0] d;
      int r;
      d = 8'($urandom);
      r = $urandom_range(0, 3);
      wait_clk($urandom_range(5, 60));
      send_frame(d, r == 1, r == 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
